// File: rtl/mole_spawner_if.sv
// Handshake and display bus between the game FSM and the mole spawner.
// The FSM side drives requests and difficulty; the spawner drives mole and timer status.
interface mole_spawner_if #(
  parameter int unsigned NUM_MOLES = 18
);
  logic                 ready_for_mole;
  logic                 timeout_start;
  logic [1:0]           level;
  logic                 mole_valid;
  logic [4:0]           mole_index;
  logic [NUM_MOLES-1:0] mole_onehot;
  logic                 timeout;
  logic [10:0]          ms_left;

  modport master (
    output ready_for_mole, timeout_start, level,
    input  mole_valid, mole_index, mole_onehot, timeout, ms_left
  );

  modport slave (
    input  ready_for_mole, timeout_start, level,
    output mole_valid, mole_index, mole_onehot, timeout, ms_left
  );
endinterface

// File: rtl/mole_spawner.sv
// Mole source and hit-window timer: picks a pseudo-random mole on request and counts down its window.
// Optional feature macro: MOLE_SPEEDUP_EN (hit streak shortens the window down to MIN_WINDOW_MS).
module mole_spawner #(
  parameter int unsigned NUM_MOLES     = 18,
  parameter int unsigned CLKS_PER_MS   = 50000,
  parameter int unsigned WINDOW_L0_MS  = 1500,
  parameter int unsigned WINDOW_L1_MS  = 1000,
  parameter int unsigned WINDOW_L2_MS  = 600,
  parameter int unsigned MIN_WINDOW_MS = 300
) (
  input  logic          clk,
  input  logic          reset,
  mole_spawner_if.slave bus
);
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned MS_W    = 11;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned PRESC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  generate
    if (NUM_MOLES < 2 || NUM_MOLES > 32) begin : g_bad_num_moles
      $error("mole_spawner: NUM_MOLES must be within 2..32");
    end
    if (CLKS_PER_MS < 1) begin : g_bad_clks
      $error("mole_spawner: CLKS_PER_MS must be at least 1");
    end
    if (WINDOW_L0_MS > 2047 || WINDOW_L1_MS > 2047 || WINDOW_L2_MS > 2047 ||
        MIN_WINDOW_MS > 2047) begin : g_bad_window
      $error("mole_spawner: windows must fit the 11-bit ms counter");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_EXPIRED
  } state_t;

  state_t              state_q;
  state_t              state_nx;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [PRESC_W-1:0]  presc_nx;
  logic                valid_nx;
  logic                timeout_nx;
  logic [IDX_W-1:0]    index_nx;
  logic [MS_W-1:0]     ms_nx;
  logic [NUM_MOLES-1:0] onehot_nx;

  logic                tick_c;
  logic                expire_c;
  logic                accept_c;
  logic [IDX_W-1:0]    cand_c;
  logic [IDX_W-1:0]    pick_c;
  logic [MS_W-1:0]     base_c;
  logic [MS_W-1:0]     window_c;

  assign tick_c   = (presc_q == PRESC_W'(CLKS_PER_MS - 1));
  // A zero window expires at once; otherwise the final tick takes ms_left from 1 to 0.
  assign expire_c = (bus.ms_left == '0) || (tick_c && (bus.ms_left == MS_W'(1)));
  assign accept_c = bus.ready_for_mole && ((state_q == ST_IDLE) || (state_q == ST_ARMED));

  // Never repeat the previous mole: bump a colliding candidate to its neighbour.
  always_comb begin
    cand_c = IDX_W'(32'(lfsr_q) % NUM_MOLES);
    pick_c = cand_c;
    if (cand_c == bus.mole_index) begin
      pick_c = ((32'(cand_c) + 32'(1)) == NUM_MOLES) ? '0 : cand_c + IDX_W'(1);
    end
  end

  always_comb begin
    case (bus.level)
      2'd0:    base_c = MS_W'(WINDOW_L0_MS);
      2'd1:    base_c = MS_W'(WINDOW_L1_MS);
      default: base_c = MS_W'(WINDOW_L2_MS);
    endcase
  end

`ifdef MOLE_SPEEDUP_EN
  localparam int unsigned STREAK_W = 6;
  localparam int unsigned CALC_W   = 13;

  logic [STREAK_W-1:0] streak_q;
  logic [CALC_W-1:0]   dec_c;

  // Every 4 consecutive hits trim 50 ms, floored at MIN_WINDOW_MS.
  always_comb begin
    dec_c = CALC_W'(50) * CALC_W'(streak_q[STREAK_W-1:2]);
    if (CALC_W'(base_c) > dec_c + CALC_W'(MIN_WINDOW_MS)) begin
      window_c = MS_W'(CALC_W'(base_c) - dec_c);
    end else begin
      window_c = MS_W'(MIN_WINDOW_MS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (!bus.timeout_start) begin
        if (streak_q != '1) streak_q <= streak_q + STREAK_W'(1);
      end else if (expire_c) begin
        streak_q <= '0;
      end
    end
  end
`else
  assign window_c = base_c;
`endif

  // State, LFSR, prescaler and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      lfsr_q          <= LFSR_SEED;
      presc_q         <= '0;
      bus.mole_valid  <= 1'b0;
      bus.mole_index  <= '0;
      bus.mole_onehot <= '0;
      bus.timeout     <= 1'b1;
      bus.ms_left     <= '0;
    end else begin
      state_q         <= state_nx;
      lfsr_q          <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
      presc_q         <= presc_nx;
      bus.mole_valid  <= valid_nx;
      bus.mole_index  <= index_nx;
      bus.mole_onehot <= onehot_nx;
      bus.timeout     <= timeout_nx;
      bus.ms_left     <= ms_nx;
    end
  end

  // Next state; a falling timeout_start in RUN beats a simultaneous expiry.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:    if (bus.ready_for_mole) state_nx = ST_ARMED;
      ST_ARMED:   if (bus.timeout_start) state_nx = ST_RUN;
      ST_RUN: begin
        if (!bus.timeout_start) state_nx = ST_IDLE;
        else if (expire_c)      state_nx = ST_EXPIRED;
      end
      ST_EXPIRED: if (!bus.timeout_start) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Next output values, registered above.
  always_comb begin
    index_nx   = bus.mole_index;
    ms_nx      = bus.ms_left;
    presc_nx   = presc_q;
    valid_nx   = (state_nx == ST_ARMED) || (state_nx == ST_RUN);
    timeout_nx = (state_nx != ST_EXPIRED);
    if (accept_c) begin
      index_nx = pick_c;
      ms_nx    = window_c;
      presc_nx = '0;
    end else if ((state_q == ST_RUN) && bus.timeout_start && !expire_c) begin
      if (tick_c) begin
        ms_nx    = bus.ms_left - MS_W'(1);
        presc_nx = '0;
      end else begin
        presc_nx = presc_q + PRESC_W'(1);
      end
    end
    if (!valid_nx) ms_nx = '0;
    onehot_nx = valid_nx ? (NUM_MOLES'(1) << index_nx) : '0;
  end
endmodule

// File: doc/mole_spawner.md
# mole_spawner

Mole source and hit-window timer for the whac-a-mole game. It answers the game FSM's `ready_for_mole` request by choosing a pseudo-random mole from a free-running LFSR and driving that mole's LED. While the FSM holds `timeout_start`, it counts down the level-dependent hit window and drops `timeout` when the window runs out. It sits between the game FSM, the LED driver and the seven-seg countdown display.

## Interface
- `NUM_MOLES`, 18: number of LEDs/switches; must be 2..32.
- `CLKS_PER_MS`, 50000: clk cycles per millisecond tick.
- `WINDOW_L0_MS`, 1500: hit window for level 0 (ms).
- `WINDOW_L1_MS`, 1000: hit window for level 1.
- `WINDOW_L2_MS`, 600: hit window for levels 2 and 3.
- `MIN_WINDOW_MS`, 300: floor on the window (used only with `MOLE_SPEEDUP_EN`).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ready_for_mole` in 1: request for a new mole; one-cycle pulse from the FSM.
- `timeout_start` in 1: high while the FSM waits for a hit.
- `level` in 2: difficulty, sampled on request accept.
- `mole_valid` out 1: a mole is currently shown.
- `mole_index` out 5: index of the current mole, 0..NUM_MOLES-1.
- `mole_onehot` out NUM_MOLES: LED drive, `1 << mole_index` when `mole_valid` is high, else 0.
- `timeout` out 1: window still open. It is high in every state except EXPIRED, so low means expired.
- `ms_left` out 11: remaining window in ms, for the display.

## Operation
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every clk.
- Candidate = `lfsr % NUM_MOLES`. If the candidate equals the previous `mole_index`, use `(candidate+1) % NUM_MOLES` instead; the same mole never appears twice in a row.
- State IDLE:
  - Outputs: `mole_valid`=0, `ms_left`=0.
  - `ready_for_mole`=1: latch index and level, load `ms_left` with the window, clear prescaler, go to ARMED.
- State ARMED:
  - Outputs: `mole_valid`=1, timer frozen.
  - `timeout_start`=1: go to RUN.
  - `ready_for_mole`=1 again: re-pick index and reload window, stay in ARMED.
- State RUN:
  - Prescaler counts 0..CLKS_PER_MS-1. On wrap, decrement `ms_left`.
  - If that decrement takes `ms_left` from 1 to 0, go to EXPIRED.
  - `timeout_start`=0 (hit or game reset): go to IDLE and count a hit.
  - `ready_for_mole` is ignored.
- State EXPIRED:
  - Outputs: `timeout`=0, `mole_valid`=0.
  - Count a miss.
  - `timeout_start`=0: go to IDLE. `ready_for_mole` is ignored.
- Simultaneous events in RUN: if `timeout_start` falls on the same cycle as the final tick, the hit wins and the next state is IDLE.
- Window of 0 ms: go straight to EXPIRED on the first RUN cycle.
- Reset values:
  - State IDLE, `mole_valid`=0, `mole_index`=0, `mole_onehot`=0, `timeout`=1, `ms_left`=0.
  - LFSR = seed; streak counter = 0.
- A reset mid-operation aborts immediately; no partial count survives.

## Timing
- `ready_for_mole` sampled high at edge N: `mole_valid`, `mole_index`, `mole_onehot` and `ms_left` are valid from edge N (registered, 1-cycle latency).
- `timeout` stays 1 through accept and RUN. The FSM may therefore check it on the cycle after its request.
- Expiry: `timeout` falls exactly W×CLKS_PER_MS cycles after the first RUN cycle, W being the loaded window.
- Return to IDLE: one edge after `timeout_start` is sampled low. The spawner is ready for a new request on the following cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `MOLE_SPEEDUP_EN` defined:
  - A 6-bit saturating streak counter increments on each hit and clears on expiry.
  - Loaded window = max(MIN_WINDOW_MS, base − 50×(streak>>2)).
- `MOLE_SPEEDUP_EN` not defined: the streak logic is absent and the window is always the level's base value.

## Test plan
All directed tests use `CLKS_PER_MS`=4, `WINDOW_L1_MS`=10, `level`=1.
- Reset at cycle 3 with a request pending -> `timeout`=1, `mole_onehot`=0, state IDLE; the next LFSR value equals the one after seed 16'hACE1.
- `ready_for_mole` pulse, then `timeout_start` high 2 cycles later and held -> `timeout` low exactly 40 cycles after the first RUN cycle, `ms_left` steps 10→0, `mole_onehot` clears on expiry.
- `timeout_start` dropped after 17 RUN cycles -> IDLE next edge, `ms_left`=0, `timeout` never low.
- 200 consecutive requests -> every `mole_index` < 18, no two consecutive indices equal, all 18 indices appear.
- Hit on the final-tick cycle -> IDLE, no EXPIRED, `timeout` stays 1.
- With `MOLE_SPEEDUP_EN`, `WINDOW_L1_MS`=400, `MIN_WINDOW_MS`=300: 4 hits -> window 350; 8 hits -> 300; 12 hits -> 300 (floor); one expiry -> 400.
